// File: rtl/round_key_store_pkg.sv
// round_key_store_pkg
//   Shared constants and types for the round-key store: table geometry,
//   key_len encodings, the key_len -> last-round-index helpers and the
//   read FSM state enum.
package round_key_store_pkg;

  localparam int NUM_KEYS = 15;   // round keys 0..14 (AES-256 worst case)
  localparam int KEY_W    = 128;  // subkey width
  localparam int AW       = 4;    // address width for waddr/raddr

  // Highest legal address. Anything above it is out of range.
  localparam logic [AW-1:0] MAX_ADDR = AW'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    KL_NONE = 2'b00,
    KL_128  = 2'b01,
    KL_192  = 2'b10,
    KL_256  = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } rd_state_e;

  // Index of the final round key for a given key length.
  function automatic logic [AW-1:0] last_idx(key_len_e kl);
    case (kl)
      KL_128:  return AW'(10);
      KL_192:  return AW'(12);
      KL_256:  return AW'(14);
      default: return '0;
    endcase
  endfunction

  // One bit per entry that must be valid before the schedule is complete.
  // Empty for KL_NONE, so callers must gate readiness on kl separately.
  function automatic logic [NUM_KEYS-1:0] need_mask(key_len_e kl);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    if (kl != KL_NONE) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (AW'(i) <= last_idx(kl)) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/round_key_store_if.sv
// round_key_store_if
//   Bundles the key-expander write port, the schedule clear, and the
//   round-datapath request/ack read port.
//   master: drives wr_valid/waddr/subkey, clr_valid/key_len, rd_req/raddr;
//           receives rd_ack/rd_key/rd_err/keys_ready.
//   slave : the store itself (directions reversed).
interface round_key_store_if;
  import round_key_store_pkg::*;

  logic             wr_valid;
  logic [AW-1:0]    waddr;
  logic [KEY_W-1:0] subkey;
  logic             clr_valid;
  logic [1:0]       key_len;
  logic             rd_req;
  logic [AW-1:0]    raddr;
  logic             rd_ack;
  logic [KEY_W-1:0] rd_key;
  logic             rd_err;
  logic             keys_ready;

  modport master (
    output wr_valid, waddr, subkey, clr_valid, key_len, rd_req, raddr,
    input  rd_ack, rd_key, rd_err, keys_ready
  );

  modport slave (
    input  wr_valid, waddr, subkey, clr_valid, key_len, rd_req, raddr,
    output rd_ack, rd_key, rd_err, keys_ready
  );

endinterface

// File: rtl/round_key_store_rf.sv
// round_key_rf
//   NUM_KEYS x KEY_W round-key array with per-entry valid bits.
//   Ports:
//     clk, reset      clock, async active-low reset (valid/key_len/ready only)
//     clr, key_len    invalidate all entries and latch the schedule length
//     wr, waddr, wdata  subkey write; out-of-range addresses are dropped
//     raddr -> rdata, rvalid  combinational read of the current contents
//     ready           registered: every entry needed for key_len is valid
module round_key_rf
  import round_key_store_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  key_len_e         key_len,
  input  logic             wr,
  input  logic [AW-1:0]    waddr,
  input  logic [KEY_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [KEY_W-1:0] rdata,
  output logic             rvalid,
  output logic             ready
);

  logic [KEY_W-1:0]    mem_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] valid_q, valid_d;
  key_len_e            key_len_q, key_len_d;
  logic                ready_q, ready_d;
  logic                wr_ok;

  assign wr_ok = wr && (waddr <= MAX_ADDR);

  // Clear is applied before the write, so a same-cycle write survives.
  // Readiness is computed from the next-state bits so keys_ready moves the
  // cycle after the final write or the clear, not two cycles later.
  always_comb begin
    valid_d   = valid_q;
    key_len_d = key_len_q;
    if (clr) begin
      valid_d   = '0;
      key_len_d = key_len;
    end
    if (wr_ok) valid_d[waddr] = 1'b1;
    ready_d = (key_len_d != KL_NONE) &&
              ((valid_d & need_mask(key_len_d)) == need_mask(key_len_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      key_len_q <= KL_NONE;
      ready_q   <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      key_len_q <= key_len_d;
      ready_q   <= ready_d;
    end
  end

  // Key storage carries no reset; the valid bits say what is meaningful.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[waddr] <= wdata;
  end

  assign rvalid = (raddr <= MAX_ADDR) && valid_q[raddr];
  assign rdata  = (raddr <= MAX_ADDR) ? mem_q[raddr] : '0;
  assign ready  = ready_q;

endmodule

// File: rtl/round_key_store.sv
// round_key_store
//   Round-key register file between the key expander and the AES round
//   datapath. Subkeys are captured as they are produced; reads stall until
//   the requested key is valid, so encryption can start once key 0 exists.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     bus    round_key_store_if.slave (write, clear and read ports)
//   Optional feature: ROUND_KEY_STORE_BYPASS_EN enables write-to-read
//   forwarding so a key written while it is being waited for acks one
//   cycle earlier.
module round_key_store
  import round_key_store_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  round_key_store_if.slave   bus
);

  logic [KEY_W-1:0] rf_rdata;
  logic             rf_rvalid;
  logic             rf_ready;

  round_key_rf u_rf (
    .clk     (clk),
    .reset   (reset),
    .clr     (bus.clr_valid),
    .key_len (key_len_e'(bus.key_len)),
    .wr      (bus.wr_valid),
    .waddr   (bus.waddr),
    .wdata   (bus.subkey),
    .raddr   (bus.raddr),
    .rdata   (rf_rdata),
    .rvalid  (rf_rvalid),
    .ready   (rf_ready)
  );

  rd_state_e        state_q, state_d;
  logic             rd_ack_q, rd_ack_d;
  logic             rd_err_q, rd_err_d;
  logic [KEY_W-1:0] rd_key_q, rd_key_d;

  logic             in_range;
  logic             hit;
  logic [KEY_W-1:0] hit_key;

  assign in_range = bus.raddr <= MAX_ADDR;

  // A stored key only counts when no clear lands in the same cycle; a key
  // that was valid under the old schedule must not satisfy the request.
`ifdef ROUND_KEY_STORE_BYPASS_EN
  logic fwd;
  assign fwd     = in_range && bus.wr_valid && (bus.waddr == bus.raddr);
  assign hit     = (in_range && rf_rvalid && !bus.clr_valid) || fwd;
  assign hit_key = fwd ? bus.subkey : rf_rdata;
`else
  assign hit     = in_range && rf_rvalid && !bus.clr_valid;
  assign hit_key = rf_rdata;
`endif

  always_comb begin
    state_d  = state_q;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;
    rd_key_d = rd_key_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.rd_req) begin
          if (!in_range) begin
            rd_err_d = 1'b1;
          end else if (hit) begin
            state_d  = ST_ACK;
            rd_ack_d = 1'b1;
            rd_key_d = hit_key;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Dropping the request early abandons it without an ack.
        if (!bus.rd_req) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          state_d  = ST_ACK;
          rd_ack_d = 1'b1;
          rd_key_d = hit_key;
        end
      end
      ST_ACK: begin
        // rd_req is ignored here so the requester can retarget raddr.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
      rd_key_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
      rd_key_q <= rd_key_d;
    end
  end

  assign bus.rd_ack     = rd_ack_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.rd_key     = rd_key_q;
  assign bus.keys_ready = rf_ready;

endmodule
